// File: rtl/cmd_pkg.sv
// cmd_pkg: shared state encoding, field widths and frame sizing for cmd_modulator (CMD_MOD_CRC_EN adds CRC-8)
package cmd_pkg;
  typedef enum logic [2:0] {IDLE, PREAMBLE, BIT_PULSE, BIT_GAP, TAIL_PULSE, TAIL_GAP} state_t;
  localparam int ORD_W = 2;
  localparam int CTG_W = 2;
  localparam int FLAG_W = 8;
  localparam int SCHEME_W = 48;
  localparam int PAYLOAD_BITS = 60;
  localparam int CRC_BITS = 8;
  localparam logic [7:0] CRC_POLY = 8'h07;
`ifdef CMD_MOD_CRC_EN
  localparam int FRAME_BITS = PAYLOAD_BITS + CRC_BITS;
`else
  localparam int FRAME_BITS = PAYLOAD_BITS;
`endif
  function automatic int max2(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/cmd_modulator_if.sv
// cmd_modulator_if: start/field inputs and outsig/busy/done outputs; master drives commands, slave is the modulator
interface cmd_modulator_if;
  import cmd_pkg::*;
  logic start;
  logic [ORD_W-1:0] ord;
  logic [CTG_W-1:0] ctg;
  logic [FLAG_W-1:0] cur_flag;
  logic [SCHEME_W-1:0] cur_scheme;
  logic outsig;
  logic busy;
  logic done;
  modport master (output start, ord, ctg, cur_flag, cur_scheme, input outsig, busy, done);
  modport slave (input start, ord, ctg, cur_flag, cur_scheme, output outsig, busy, done);
endinterface

// File: rtl/cmd_crc8.sv
// cmd_crc8: combinational CRC-8 (poly 0x07, init 0, no reflection) over the 60-bit payload, MSB first; in: data, out: crc
module cmd_crc8
  import cmd_pkg::*;
(
  input  logic [PAYLOAD_BITS-1:0] data,
  output logic [CRC_BITS-1:0]     crc
);
  always_comb begin
    crc = '0;
    for (int i = PAYLOAD_BITS - 1; i >= 0; i--)
      crc = {crc[CRC_BITS-2:0], 1'b0} ^ ((crc[CRC_BITS-1] ^ data[i]) ? CRC_POLY : '0);
  end
endmodule

// File: rtl/cmd_modulator.sv
// cmd_modulator: pulse-interval command transmitter; ports clock, reset (sync, active-low), io (cmd_modulator_if.slave); CMD_MOD_CRC_EN appends CRC-8
module cmd_modulator
  import cmd_pkg::*;
#(
  parameter int PREAMBLE_LEN = 64,
  parameter int PULSE_LEN    = 8,
  parameter int ZERO_GAP     = 8,
  parameter int ONE_GAP      = 24,
  parameter int END_GAP      = 32
) (
  input logic          clock,
  input logic          reset,
  cmd_modulator_if.slave io
);
  localparam int CW = $clog2(max2(max2(max2(PREAMBLE_LEN, PULSE_LEN), max2(ZERO_GAP, ONE_GAP)), END_GAP)) + 1;
  localparam int BW = $clog2(FRAME_BITS + 1);
  localparam logic [CW-1:0] L_PRE  = CW'(PREAMBLE_LEN - 1);
  localparam logic [CW-1:0] L_PUL  = CW'(PULSE_LEN - 1);
  localparam logic [CW-1:0] L_ZERO = CW'(ZERO_GAP - 1);
  localparam logic [CW-1:0] L_ONE  = CW'(ONE_GAP - 1);
  localparam logic [CW-1:0] L_END  = CW'(END_GAP - 1);
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [FRAME_BITS-1:0] sr, sr_load;
  logic [PAYLOAD_BITS-1:0] word;
  logic [BW-1:0] bits;
  logic accept, tick, shift;
  logic outsig_d, busy_d, done_d;
  logic outsig_q, busy_q, done_q;
  assign word = {io.ord, io.ctg, io.cur_flag, io.cur_scheme};
`ifdef CMD_MOD_CRC_EN
  logic [CRC_BITS-1:0] crc;
  cmd_crc8 u_crc (.data(word), .crc(crc));
  assign sr_load = {word, crc};
`else
  assign sr_load = word;
`endif
  assign accept = state == IDLE && io.start;
  assign tick = cnt == '0;
  assign shift = state == BIT_GAP && tick;
  always_ff @(posedge clock) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      sr       <= '0;
      bits     <= '0;
      outsig_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      sr       <= accept ? sr_load : shift ? sr << 1 : sr;
      bits     <= accept ? '0 : shift ? bits + 1'b1 : bits;
      outsig_q <= outsig_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end
  // Each state loads its duration minus one on entry and counts down to 0.
  always_comb begin
    state_n = state;
    cnt_n = tick ? cnt : cnt - 1'b1;
    unique case (state)
      IDLE: begin
        state_n = io.start ? PREAMBLE : IDLE;
        cnt_n = io.start ? L_PRE : '0;
      end
      PREAMBLE: if (tick) begin
        state_n = BIT_PULSE;
        cnt_n = L_PUL;
      end
      BIT_PULSE: if (tick) begin
        state_n = BIT_GAP;
        cnt_n = sr[FRAME_BITS-1] ? L_ONE : L_ZERO;
      end
      BIT_GAP: if (tick) begin
        state_n = bits == BW'(FRAME_BITS - 1) ? TAIL_PULSE : BIT_PULSE;
        cnt_n = L_PUL;
      end
      TAIL_PULSE: if (tick) begin
        state_n = TAIL_GAP;
        cnt_n = L_END;
      end
      TAIL_GAP: if (tick) begin
        state_n = IDLE;
        cnt_n = '0;
      end
      default: begin
        state_n = IDLE;
        cnt_n = '0;
      end
    endcase
  end
  // Outputs are registered from the next state so they change on the same edge as the state.
  always_comb begin
    outsig_d = state_n inside {PREAMBLE, BIT_PULSE, TAIL_PULSE};
    busy_d = state_n != IDLE;
    done_d = state == TAIL_GAP && tick;
  end
  assign io.outsig = outsig_q;
  assign io.busy = busy_q;
  assign io.done = done_q;
endmodule
